// File: rtl/discriminator_hyst_mc.sv
// Multi-channel Schmitt-trigger discriminator with dwell deglitch, edge pulses
// and saturating rising-edge event counters.
module discriminator_hyst_mc #(
   parameter int ADC_WIDTH        = 12,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int NUM_CH           = 2,
   parameter int DWELL_WIDTH      = 8,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_IN_tdata,
   input  logic                          S_AXIS_IN_tvalid,
   input  logic [NUM_CH*ADC_WIDTH-1:0]   high_thr,
   input  logic [NUM_CH*ADC_WIDTH-1:0]   low_thr,
   input  logic [DWELL_WIDTH-1:0]        dwell,
   input  logic                          clear_cnt,
   output logic [NUM_CH-1:0]             state_out,
   output logic [NUM_CH-1:0]             rise_pulse,
   output logic [NUM_CH-1:0]             fall_pulse,
   output logic [NUM_CH*CNT_WIDTH-1:0]   rise_count
);

   typedef enum logic [1:0] {LOW, ARM_HI, HIGH, ARM_LO} state_t;

   localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);

   // Bits between channel lanes are not used by any channel.
   logic unused_tdata;
   assign unused_tdata = ^S_AXIS_IN_tdata;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic signed [ADC_WIDTH-1:0] sample;
      logic signed [ADC_WIDTH-1:0] hi;
      logic signed [ADC_WIDTH-1:0] lo;
      logic                        above;
      logic                        below;
      logic                        rise_ev;
      logic                        fall_ev;
      state_t                      st;
      logic [DWELL_WIDTH-1:0]      cnt;
      logic                        st_out_q;
      logic                        rise_q;
      logic                        fall_q;
      logic [CNT_WIDTH-1:0]        count_q;

      assign sample = S_AXIS_IN_tdata[16*c +: ADC_WIDTH];
      assign hi     = high_thr[c*ADC_WIDTH +: ADC_WIDTH];
      assign lo     = low_thr[c*ADC_WIDTH +: ADC_WIDTH];

      // ABOVE wins when the thresholds are inverted.
      always_comb begin
         above = (sample > hi);
         below = !above && (sample < lo);
      end

      always_comb begin
         rise_ev = 1'b0;
         fall_ev = 1'b0;
         if (S_AXIS_IN_tvalid) begin
            rise_ev = above && ((st == LOW    && dwell == '0) ||
                                (st == ARM_HI && cnt >= dwell));
            fall_ev = below && ((st == HIGH   && dwell == '0) ||
                                (st == ARM_LO && cnt >= dwell));
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st       <= LOW;
            cnt      <= '0;
            st_out_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
         end else begin
            rise_q <= rise_ev;
            fall_q <= fall_ev;
            if (S_AXIS_IN_tvalid) begin
               unique case (st)
                  LOW: begin
                     if (rise_ev) begin
                        st       <= HIGH;
                        st_out_q <= 1'b1;
                     end else if (above) begin
                        st  <= ARM_HI;
                        cnt <= DWELL_ONE;
                     end
                  end
                  ARM_HI: begin
                     if (rise_ev) begin
                        st       <= HIGH;
                        cnt      <= '0;
                        st_out_q <= 1'b1;
                     end else if (above) begin
                        cnt <= cnt + DWELL_ONE;
                     end else begin
                        st  <= LOW;
                        cnt <= '0;
                     end
                  end
                  HIGH: begin
                     if (fall_ev) begin
                        st       <= LOW;
                        st_out_q <= 1'b0;
                     end else if (below) begin
                        st  <= ARM_LO;
                        cnt <= DWELL_ONE;
                     end
                  end
                  ARM_LO: begin
                     if (fall_ev) begin
                        st       <= LOW;
                        cnt      <= '0;
                        st_out_q <= 1'b0;
                     end else if (below) begin
                        cnt <= cnt + DWELL_ONE;
                     end else begin
                        st  <= HIGH;
                        cnt <= '0;
                     end
                  end
                  default: begin
                     st  <= LOW;
                     cnt <= '0;
                  end
               endcase
            end
         end
      end

      // Counter updates on the same edge that raises rise_pulse, so a clear
      // coinciding with a rise leaves exactly that one event counted.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            count_q <= '0;
         end else if (clear_cnt) begin
            count_q <= rise_ev ? CNT_ONE : '0;
         end else if (rise_ev && count_q != '1) begin
            count_q <= count_q + CNT_ONE;
         end
      end

      assign state_out[c]                       = st_out_q;
      assign rise_pulse[c]                      = rise_q;
      assign fall_pulse[c]                      = fall_q;
      assign rise_count[c*CNT_WIDTH +: CNT_WIDTH] = count_q;
   end

endmodule
